lcd_text_arbiter: RTL and testbench
===================================

// Module: lcd_text_arbiter
// PURPOSE
//  Owns the 32-cell (2x16) character frame buffer that drives the 1602 LCD controller's row_A/row_B inputs.
//  Shares the buffer between NUM_REQ single-character writers using round-robin arbitration with a req/ack handshake.
//  Provides a sequenced clear sweep that fills the buffer with CLR_CHAR.
//  Sits between application logic (counters, UART, menus) and the LCD controller; 100 MHz clk domain.
// PARAMETERS
//  NUM_REQ   4      number of writer ports (2..8)
//  CLR_CHAR  8'h20  character written by reset and by the clear sweep (ASCII space)
// PORTS
//  clk      in   1          system clock, 100 MHz; single clock domain
//  reset_n  in   1          asynchronous, active-low reset
//  req      in   NUM_REQ    per-writer write request (level); hold until ack
//  wr_addr  in   NUM_REQ*5  per-writer cell address, slice i = [5i+4:5i]; 0-15 row A, 16-31 row B
//  wr_data  in   NUM_REQ*8  per-writer character code, slice i = [8i+7:8i]
//  clr_req  in   1          level request to clear the whole buffer
//  lock     in   NUM_REQ    exclusive-ownership request (only with LCD_ARB_LOCK_EN)
//  ack      out  NUM_REQ    one-cycle pulse: the writer's cell was updated this cycle
//  busy     out  1          high while the clear sweep runs
//  row_A    out  128        cells 0-15; cell 0 = [127:120], cell 15 = [7:0]
//  row_B    out  128        cells 16-31; same packing
// BEHAVIOUR
//  - Reset: all 32 cells = CLR_CHAR, ack=0, busy=0, state IDLE, rr_ptr=NUM_REQ-1 (writer 0 wins first), owner=none.
//  - Arbitration, IDLE only: eligible = req & ~ack. Winner = first eligible index after rr_ptr, searching upward with wrap.
//  - Write latency is 1 cycle. For winner g sampled at edge t: at t+1 the cell wr_addr[g] holds wr_data[g], ack[g]=1, rr_ptr=g.
//  - At most one grant per cycle. The writer is masked in its ack cycle, so a held req cannot double-write.
//  - Writers drop req, or present new addr/data, in the ack cycle. Data is sampled only at the grant edge.
//  - Two writers targeting the same cell in consecutive cycles: last write wins. No merging.
//  - FSM IDLE->CLEAR when clr_req=1 in IDLE. clr_req has priority over all writes that cycle (no ack).
//  - CLEAR: one cell per cycle, clr_idx 0..31, cell[clr_idx]=CLR_CHAR. busy=1 from the first sweep cycle to the last.
//  - CLEAR takes exactly 32 cycles. After clr_idx=31, return to IDLE, clr_idx=0, busy=0.
//  - During CLEAR: no acks, requests stay pending, clr_req is ignored. clr_req still high on return re-enters CLEAR.
//  - row_A/row_B are direct register outputs with no combinational path from inputs. Mid-sweep frames may show a partial clear.
//  - reset_n low at any time, including mid-sweep or in an ack cycle, forces the reset state immediately. Partial operations are discarded.
// CONFIGURATION
//  LCD_ARB_LOCK_EN defined:
//  - The lock port exists.
//  - Writer i becomes owner when acked while lock[i]=1.
//  - While owned, only the owner is eligible and clr_req is held off (not dropped).
//  - Ownership is released in the first cycle the owner's lock=0. The next arbitration then resumes from rr_ptr.
//  - Ownership is cleared by reset.
//  LCD_ARB_LOCK_EN undefined:
//  - The lock port and owner register are absent.
//  - Arbitration is pure round-robin as above.
// STRUCTURE
//  Package lcd_arb_pkg:
//  - LCD_COLS=16, LCD_CELLS=32, CELL_AW=5, CHAR_W=8.
//  - state_t enum {ST_IDLE, ST_CLEAR}.
//  - Function cell_slice(idx) returning the row/bit offset.
//  Sub-module lcd_rr_arbiter (NUM_REQ):
//  - Inputs eligible and rr_ptr.
//  - Outputs a one-hot grant and its index, combinational.
//  - All registers stay in lcd_text_arbiter.
// TESTING
//  1 Reset release -> row_A = row_B = {16{8'h20}}, busy=0, ack=0.
//  2 req[0] addr=0 data=8'h41 -> next cycle ack[0]=1, row_A[127:120]=8'h41, other cells unchanged.
//  3 req=4'b1111 held, addrs 1..4 distinct -> acks in order 0,1,2,3, one per cycle; each cell written exactly once.
//  4 Fill all cells with 8'h58, pulse clr_req one cycle -> busy=1 for exactly 32 cycles, cells revert in order 0..31, no acks.
//    A req[1] raised during the sweep is acked on the first cycle after busy falls.
//  5 LCD_ARB_LOCK_EN: lock[2]=1 with req[2] -> owner=2; req[0] plus clr_req are starved.
//    Drop lock[2] -> CLEAR runs first, then writer 0 is acked.
//  6 Assert reset_n=0 at clr_idx=10 -> all cells = 8'h20 at once, busy=0; after release, normal arbitration from writer 0.

Source files
------------

// File: rtl/lcd_arb_pkg.sv
// ============================================================================
// Module   : lcd_arb_pkg
// Purpose  : Shared geometry, FSM encoding and cell-packing helper for the
//            1602 LCD text arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_arb_pkg;

  localparam int LCD_COLS  = 16;
  localparam int LCD_CELLS = 32;
  localparam int CELL_AW   = 5;
  localparam int CHAR_W    = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Returns {row, bit offset within that row}: row 0 = row_A, row 1 = row_B.
  // The leftmost column of each row sits in the most significant byte.
  function automatic logic [7:0] cell_slice(input logic [CELL_AW-1:0] idx);
    logic [3:0] col;
    col = 4'(LCD_COLS - 1) - idx[3:0];
    return {idx[4], col, 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_rr_arbiter.sv
// ============================================================================
// Module   : lcd_rr_arbiter
// Purpose  : Combinational round-robin picker: first eligible index after
//            rr_ptr, searching upward with wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int cand;
    cand        = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Offset 1 first so the most recent winner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_text_arbiter.sv
// ============================================================================
// Module   : lcd_text_arbiter
// Purpose  : 2x16 character frame buffer shared by NUM_REQ writers through
//            round-robin req/ack arbitration, with a 32-cycle clear sweep.
//            Optional exclusive ownership enabled by macro LCD_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_text_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int          NUM_REQ  = 4,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*5-1:0]   wr_addr,
  input  logic [NUM_REQ*8-1:0]   wr_data,
  input  logic                   clr_req,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic [127:0]           row_A,
  output logic [127:0]           row_B
`ifdef LCD_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]     lock
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                 state_q, state_d;
  logic [CELL_AW-1:0]     clr_idx_q, clr_idx_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [CHAR_W-1:0]      cells_q [LCD_CELLS];
  logic [CHAR_W-1:0]      cells_d [LCD_CELLS];

  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     grant;
  logic [IW-1:0]          grant_idx;
  logic                   grant_valid;
  logic [CELL_AW-1:0]     win_addr;
  logic [CHAR_W-1:0]      win_data;
  logic                   owned;

`ifdef LCD_ARB_LOCK_EN
  logic                   owner_valid_q, owner_valid_d;
  logic [IW-1:0]          owner_idx_q, owner_idx_d;
  logic [NUM_REQ-1:0]     owner_mask;

  // Ownership lapses in the very cycle the owner lowers lock.
  assign owned = owner_valid_q & lock[owner_idx_q];

  always_comb begin
    owner_mask = '1;
    if (owned) begin
      owner_mask              = '0;
      owner_mask[owner_idx_q] = 1'b1;
    end
  end

  assign eligible = req & ~ack_q & owner_mask;
`else
  assign owned    = 1'b0;
  assign eligible = req & ~ack_q;
`endif

  lcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign win_addr = wr_addr[int'(grant_idx)*CELL_AW +: CELL_AW];
  assign win_data = wr_data[int'(grant_idx)*CHAR_W  +: CHAR_W];

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rr_ptr_d  = rr_ptr_q;
    ack_d     = '0;
    cells_d   = cells_q;
`ifdef LCD_ARB_LOCK_EN
    owner_valid_d = owned;
    owner_idx_d   = owner_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A clear request pre-empts every writer; an owner holds it off.
        if (clr_req && !owned) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end else if (grant_valid) begin
          cells_d[win_addr] = win_data;
          ack_d             = grant;
          rr_ptr_d          = grant_idx;
`ifdef LCD_ARB_LOCK_EN
          if (lock[grant_idx]) begin
            owner_valid_d = 1'b1;
            owner_idx_d   = grant_idx;
          end
`endif
        end
      end
      ST_CLEAR: begin
        cells_d[clr_idx_q] = CLR_CHAR;
        if (clr_idx_q == CELL_AW'(LCD_CELLS - 1)) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
      rr_ptr_q  <= IW'(NUM_REQ - 1);
      ack_q     <= '0;
      for (int i = 0; i < LCD_CELLS; i++) begin
        cells_q[i] <= CLR_CHAR;
      end
`ifdef LCD_ARB_LOCK_EN
      owner_valid_q <= 1'b0;
      owner_idx_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      ack_q     <= ack_d;
      cells_q   <= cells_d;
`ifdef LCD_ARB_LOCK_EN
      owner_valid_q <= owner_valid_d;
      owner_idx_q   <= owner_idx_d;
`endif
    end
  end

  assign ack  = ack_q;
  assign busy = (state_q == ST_CLEAR);

  for (genvar i = 0; i < LCD_CELLS; i++) begin : g_cell
    localparam logic [7:0] SL = cell_slice(CELL_AW'(i));
    if (SL[7]) begin : g_row_b
      assign row_B[SL[6:0] +: CHAR_W] = cells_q[i];
    end else begin : g_row_a
      assign row_A[SL[6:0] +: CHAR_W] = cells_q[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_text_arbiter.sv
// ============================================================================
// Module   : tb_lcd_text_arbiter
// Purpose  : Directed self-checking bench for lcd_text_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_text_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*5-1:0] wr_addr;
  logic [N*8-1:0] wr_data;
  logic           clr_req;
  logic [N-1:0]   ack;
  logic           busy;
  logic [127:0]   row_A;
  logic [127:0]   row_B;
`ifdef LCD_ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif

  int errors;
  int checks;
  logic [7:0] exp_cells [32];

  lcd_text_arbiter #(
    .NUM_REQ  (N),
    .CLR_CHAR (8'h20)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_req (clr_req),
    .ack     (ack),
    .busy    (busy),
    .row_A   (row_A),
    .row_B   (row_B)
`ifdef LCD_ARB_LOCK_EN
    ,
    .lock    (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] exp_row(input int r);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < 16; j++) v[127-8*j -: 8] = exp_cells[r*16+j];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_writer(input int w, input logic [4:0] a, input logic [7:0] d);
    wr_addr[w*5 +: 5] = a;
    wr_data[w*8 +: 8] = d;
  endtask

  task automatic fill_exp(input logic [7:0] v);
    for (int i = 0; i < 32; i++) exp_cells[i] = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #23;
    reset_n = 1'b1;
    step();
    fill_exp(8'h20);
    checks++; if (row_A !== exp_row(0)) begin errors++; $display("FAIL reset_row_A got=%h exp=%h", row_A, exp_row(0)); end
    checks++; if (row_B !== exp_row(1)) begin errors++; $display("FAIL reset_row_B got=%h exp=%h", row_B, exp_row(1)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
  endtask

  task automatic test_single_write();
    set_writer(0, 5'd0, 8'h41);
    req = 4'b0001;
    step();
    exp_cells[0] = 8'h41;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b exp=0001", ack); end
    checks++; if (row_A !== exp_row(0)) begin errors++; $display("FAIL single_row_A got=%h exp=%h", row_A, exp_row(0)); end
    checks++; if (row_B !== exp_row(1)) begin errors++; $display("FAIL single_row_B got=%h exp=%h", row_B, exp_row(1)); end
    req = 4'b0000;
    step();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_drop got=%b exp=0000", ack); end
  endtask

  // rr_ptr is 0 after the single write, so the order is 1,2,3,0.
  task automatic test_round_robin();
    logic [3:0] order [4];
    order[0] = 4'b0010; order[1] = 4'b0100; order[2] = 4'b1000; order[3] = 4'b0001;
    for (int w = 0; w < 4; w++) set_writer(w, 5'(w + 1), 8'(8'h61 + w));
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (ack !== order[k]) begin errors++; $display("FAIL rr_ack_%0d got=%b exp=%b", k, ack, order[k]); end
      req = req & ~ack;
    end
    for (int w = 0; w < 4; w++) exp_cells[w + 1] = 8'(8'h61 + w);
    step();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rr_ack_idle got=%b exp=0000", ack); end
    checks++; if (row_A !== exp_row(0)) begin errors++; $display("FAIL rr_row_A got=%h exp=%h", row_A, exp_row(0)); end
  endtask

  task automatic test_back_to_back();
    // Held request is masked in its ack cycle, new addr/data taken next grant.
    set_writer(0, 5'd5, 8'h30);
    req = 4'b0001;
    step();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL b2b_ack1 got=%b exp=0001", ack); end
    set_writer(0, 5'd6, 8'h31);
    step();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL b2b_masked got=%b exp=0000", ack); end
    step();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL b2b_ack2 got=%b exp=0001", ack); end
    req = 4'b0000;
    exp_cells[5] = 8'h30;
    exp_cells[6] = 8'h31;
    // Same cell, consecutive writers: last write wins.
    set_writer(1, 5'd7, 8'h70);
    req = 4'b0010;
    step();
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL lww_ack1 got=%b exp=0010", ack); end
    set_writer(2, 5'd7, 8'h71);
    req = 4'b0100;
    step();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL lww_ack2 got=%b exp=0100", ack); end
    req = 4'b0000;
    exp_cells[7] = 8'h71;
    step();
    checks++; if (row_A !== exp_row(0)) begin errors++; $display("FAIL lww_row_A got=%h exp=%h", row_A, exp_row(0)); end
  endtask

  task automatic test_clear();
    for (int a = 0; a < 32; a++) begin
      set_writer(0, 5'(a), 8'h58);
      req = 4'b0001;
      step();
      req = 4'b0000;
      step();
    end
    fill_exp(8'h58);
    checks++; if (row_A !== exp_row(0)) begin errors++; $display("FAIL fill_row_A got=%h exp=%h", row_A, exp_row(0)); end
    checks++; if (row_B !== exp_row(1)) begin errors++; $display("FAIL fill_row_B got=%h exp=%h", row_B, exp_row(1)); end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    set_writer(1, 5'd9, 8'h42);
    req = 4'b0010;
    for (int k = 0; k < 32; k++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_%0d got=%b exp=1", k, busy); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL clr_ack_%0d got=%b exp=0000", k, ack); end
      checks++; if ({row_A, row_B} !== {exp_row(0), exp_row(1)}) begin errors++; $display("FAIL clr_rows_%0d got=%h_%h exp=%h_%h", k, row_A, row_B, exp_row(0), exp_row(1)); end
      step();
      exp_cells[k] = 8'h20;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_end got=%b exp=0", busy); end
    checks++; if ({row_A, row_B} !== {exp_row(0), exp_row(1)}) begin errors++; $display("FAIL clr_rows_end got=%h_%h exp=%h_%h", row_A, row_B, exp_row(0), exp_row(1)); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL clr_ack_end got=%b exp=0000", ack); end
    step();
    exp_cells[9] = 8'h42;
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL clr_pending_ack got=%b exp=0010", ack); end
    checks++; if (row_A !== exp_row(0)) begin errors++; $display("FAIL clr_pending_row got=%h exp=%h", row_A, exp_row(0)); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_sweep();
    set_writer(3, 5'd20, 8'h55);
    req = 4'b1000;
    step();
    req = 4'b0000;
    exp_cells[20] = 8'h55;
    checks++; if (row_B !== exp_row(1)) begin errors++; $display("FAIL pre_rst_row_B got=%h exp=%h", row_B, exp_row(1)); end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) step();
    reset_n = 1'b0;
    #1;
    fill_exp(8'h20);
    checks++; if (row_A !== exp_row(0)) begin errors++; $display("FAIL mid_rst_row_A got=%h exp=%h", row_A, exp_row(0)); end
    checks++; if (row_B !== exp_row(1)) begin errors++; $display("FAIL mid_rst_row_B got=%h exp=%h", row_B, exp_row(1)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    #2;
    reset_n = 1'b1;
    for (int w = 0; w < 4; w++) set_writer(w, 5'(w + 10), 8'(8'h50 + w));
    req = 4'b1111;
    step();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL post_rst_first got=%b exp=0001", ack); end
    req = 4'b0000;
    step();
  endtask

`ifdef LCD_ARB_LOCK_EN
  task automatic test_lock();
    int guard;
    set_writer(2, 5'd2, 8'h32);
    lock = 4'b0100;
    req  = 4'b0100;
    step();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL lock_grant got=%b exp=0100", ack); end
    req = 4'b0001;
    set_writer(0, 5'd0, 8'h30);
    clr_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({busy, ack} !== 5'b0) begin errors++; $display("FAIL lock_starve_%0d got=%b exp=00000", k, {busy, ack}); end
    end
    lock = 4'b0000;
    step();
    clr_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_clear_first got=%b exp=1", busy); end
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    checks++; if (guard >= 40) begin errors++; $display("FAIL lock_clear_timeout got=%0d exp<40", guard); end
    step();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL lock_resume got=%b exp=0001", ack); end
    req = 4'b0000;
    step();
  endtask
`endif

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    req     = '0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 1'b0;
`ifdef LCD_ARB_LOCK_EN
    lock    = '0;
`endif
    test_reset();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
`ifdef LCD_ARB_LOCK_EN
    test_reset();
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
